tag_lookup_ctrl: RTL and testbench
==================================

// Module: tag_lookup_ctrl
// PURPOSE
//  Lookup/fill side of the 8-way cache tag store. Reads the eight stored tags, compares them
//  against a requested tag and returns hit/way. Tracks per-way valid bits and tree pseudo-LRU state.
//  On a miss with allocate, it picks a victim way and drives the one-hot write enable and tag into the tag array.
//  Sits between the cache request pipeline and the tag array instance.
// PARAMETERS
//  TAG_W  24  tag width in bits; must equal the tag array width
//  WAYS   8   number of ways; fixed at 8 (7-bit PLRU tree)
//  WAY_W  3   log2(WAYS)
// PORTS
//  clk         in   1            clock; all state updates on rising edge
//  reset       in   1            reset, synchronous, active-high
//  req_valid   in   1            lookup request valid
//  req_ready   out  1            controller can accept a request (high only in IDLE and flush=0)
//  req_tag     in   TAG_W        tag to look up
//  req_alloc   in   1            on miss, allocate a way and write req_tag
//  flush       in   1            invalidate all ways (accepted in IDLE only)
//  resp_valid  out  1            response valid; held until resp_ready
//  resp_ready  in   1            consumer accepts response
//  resp_hit    out  1            1 = tag hit; 0 = miss (filled or not)
//  resp_way    out  WAY_W        hit way, or way filled on allocate-miss; 0 on plain miss
//  tag_we      out  WAYS         one-hot write enable to tag array
//  tag_wdata   out  TAG_W        tag written to the selected way
//  tag_rd      in   WAYS*TAG_W   stored tags; way w at bits [w*TAG_W +: TAG_W]
//  multi_hit   out  1            sticky error: more than one valid way matched; cleared only by reset
// BEHAVIOUR
//  - Reset values: state=IDLE, valid=0, plru=7'b0, req_ready=0 during reset, resp_valid=0,
//    resp_hit=0, resp_way=0, tag_we=0, tag_wdata=0, multi_hit=0.
//  - Reset mid-operation aborts any lookup or fill. No response is issued.
//  - FSM states: IDLE, COMPARE, FILL, RESP.
//  - IDLE:
//    - flush=1 clears valid[] and plru in that cycle, with priority over req_valid; stay in IDLE.
//    - Otherwise, if req_valid&&req_ready, latch req_tag and req_alloc, then go to COMPARE.
//  - COMPARE:
//    - match[w] = valid[w] && tag_rd[w] == latched tag.
//    - Any match: lowest-index matching way wins. Set multi_hit if popcount>1. Touch PLRU with that way.
//      Then go to RESP with hit=1, way=w.
//    - No match and alloc=0: go to RESP with hit=0, way=0. PLRU is unchanged.
//    - No match and alloc=1: go to FILL.
//  - FILL (exactly 1 cycle):
//    - Victim = lowest-index invalid way if any, else the PLRU victim.
//    - Drive tag_we=onehot(victim) and tag_wdata=latched tag. Set valid[victim]. Touch PLRU with victim.
//    - Go to RESP with hit=0, way=victim.
//    - The tag array captures on the following falling edge, so tag_rd shows the new value by the next rising edge.
//  - RESP: resp_valid=1 with stable resp_hit/resp_way; on resp_ready go to IDLE (req_ready returns next cycle).
//  - tag_we is 0 in every state except FILL.
//  - Latency from the accept edge to resp_valid: 2 cycles (hit or plain miss), 3 cycles (allocate-miss).
//  - PLRU tree encoding:
//    - node 0 = root, node 1 = ways 0-3, node 2 = ways 4-7, nodes 3..6 = way pairs {0,1},{2,3},{4,5},{6,7}.
//    - Bit 0 means the victim is on the low side.
//    - A touch sets each node on the accessed path to point away from the accessed way.
//    - All-zero PLRU selects way 0.
//  - flush while not IDLE is ignored. The requester holds flush until req_ready-qualified idle.
// STRUCTURE
//  - Shared package/include: TAG_W, WAYS, WAY_W constants; FSM state encodings (IDLE=0, COMPARE=1, FILL=2, RESP=3).
//  - Sub-module plru_tree8: holds the 7-bit state; inputs touch_en and touch_way; output victim_way; synchronous clear.
//  - The top level holds the FSM, valid[], compare/priority logic, fill drive and the response register.
// TESTING
//  1. After reset, lookup tag 24'h000000 with alloc=0 -> resp_hit=0, way=0 at accept+2; tag_we never asserted.
//  2. Alloc-miss 24'hABC123 -> at accept+2 tag_we=8'h01 and tag_wdata=24'hABC123 for 1 cycle;
//     resp_hit=0, way=0 at accept+3. A second lookup of 24'hABC123 -> hit, way=0.
//  3. Alloc 8 distinct tags T0..T7 -> ways 0..7 in order. Hit T0, T4, T2 -> the next alloc-miss victim is way 6
//     per the PLRU tree; valid stays 8'hFF.
//  4. Hold resp_ready=0 for 5 cycles -> resp_valid and resp_way stable, req_ready=0.
//     Release -> IDLE next cycle, new request accepted.
//  5. flush and req_valid together in IDLE -> flush wins, request not accepted.
//     Re-issue a lookup of a previously stored tag -> miss; alloc -> way 0.
//  6. Assert reset during FILL -> tag_we=0 the next cycle, no resp_valid, valid=0.
//     Also force two ways to the same tag via a bench backdoor -> hit on the lower way, multi_hit=1 sticky.

Source files
------------

// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared constants, FSM encoding and a priority helper for the tag lookup controller.
package tag_lookup_ctrl_pkg;

  localparam int TAG_W = 24;
  localparam int WAYS  = 8;
  localparam int WAY_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FILL    = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) r = WAY_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/tag_lookup_ctrl_if.sv
// Request/response handshake plus the tag array port of the lookup controller.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid holds its payload stable until then and never waits on ready.
interface tag_lookup_ctrl_if;
  import tag_lookup_ctrl_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [TAG_W-1:0]       req_tag;
  logic                   req_alloc;
  logic                   flush;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_hit;
  logic [WAY_W-1:0]       resp_way;
  logic [WAYS-1:0]        tag_we;
  logic [TAG_W-1:0]       tag_wdata;
  logic [WAYS*TAG_W-1:0]  tag_rd;
  logic                   multi_hit;

  // Requester / tag array side.
  modport master (
    output req_valid, req_tag, req_alloc, flush, resp_ready, tag_rd,
    input  req_ready, resp_valid, resp_hit, resp_way, tag_we, tag_wdata, multi_hit
  );

  // Controller side.
  modport slave (
    input  req_valid, req_tag, req_alloc, flush, resp_ready, tag_rd,
    output req_ready, resp_valid, resp_hit, resp_way, tag_we, tag_wdata, multi_hit
  );
endinterface

// File: rtl/tag_lookup_ctrl_plru_tree8.sv
// 7-bit tree pseudo-LRU for 8 ways. Node 0 is the root, nodes 1/2 cover ways
// 0-3/4-7, nodes 3..6 cover way pairs. A 0 bit points the victim to the low side.
module plru_tree8
  import tag_lookup_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             touch_en,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim_way,
  output logic [6:0]       plru_dbg
);

  logic [6:0] bits;
  logic [6:0] bits_nxt;

  // Touch: every node on the accessed path points away from the accessed way.
  always_comb begin
    bits_nxt = bits;
    if (touch_en) begin
      bits_nxt[0] = ~touch_way[2];
      if (touch_way[2]) bits_nxt[2] = ~touch_way[1];
      else              bits_nxt[1] = ~touch_way[1];
      case (touch_way[2:1])
        2'd0:    bits_nxt[3] = ~touch_way[0];
        2'd1:    bits_nxt[4] = ~touch_way[0];
        2'd2:    bits_nxt[5] = ~touch_way[0];
        default: bits_nxt[6] = ~touch_way[0];
      endcase
    end
  end

  // Tree state register; clear (flush) wins over a touch.
  always_ff @(posedge clk) begin
    if (reset || clear) bits <= '0;
    else                bits <= bits_nxt;
  end

  // Victim walk from the root following the pointer bits.
  always_comb begin
    victim_way    = '0;
    victim_way[2] = bits[0];
    victim_way[1] = bits[0] ? bits[2] : bits[1];
    case ({victim_way[2], victim_way[1]})
      2'd0:    victim_way[0] = bits[3];
      2'd1:    victim_way[0] = bits[4];
      2'd2:    victim_way[0] = bits[5];
      default: victim_way[0] = bits[6];
    endcase
  end

  assign plru_dbg = bits;

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Lookup/fill controller for the 8-way tag store: compares the latched tag
// against all ways, reports hit/way, and on allocate-miss writes a victim way.
module tag_lookup_ctrl
  import tag_lookup_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  tag_lookup_ctrl_if.slave   bus,
  output state_t             state_dbg
);

  state_t            state, state_nxt;
  logic [WAYS-1:0]   valid;
  logic [TAG_W-1:0]  lat_tag;
  logic              lat_alloc;
  logic              resp_hit_q;
  logic [WAY_W-1:0]  resp_way_q;
  logic              multi_q;

  logic [WAYS-1:0]   match;
  logic              hit_any;
  logic              hit_multi;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  plru_victim;
  logic [WAY_W-1:0]  victim;
  logic              touch_en;
  logic [WAY_W-1:0]  touch_way;
  logic              flush_now;
  logic [6:0]        plru_state;

  assign flush_now = (state == IDLE) && bus.flush;

  // Per-way tag match against the latched request tag.
  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid[w] && (bus.tag_rd[w*TAG_W +: TAG_W] == lat_tag);
    end
  end

  assign hit_any   = |match;
  assign hit_multi = (match & (match - 1'b1)) != '0;
  assign hit_way   = lowest_set(match);
  assign victim    = (&valid) ? plru_victim : lowest_set(~valid);

  plru_tree8 u_plru (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush_now),
    .touch_en   (touch_en),
    .touch_way  (touch_way),
    .victim_way (plru_victim),
    .plru_dbg   (plru_state)
  );

  // Next-state and PLRU touch selection.
  always_comb begin
    state_nxt = state;
    touch_en  = 1'b0;
    touch_way = '0;
    case (state)
      IDLE: begin
        if (!bus.flush && bus.req_valid) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit_any) begin
          touch_en  = 1'b1;
          touch_way = hit_way;
          state_nxt = RESP;
        end else if (lat_alloc) begin
          state_nxt = FILL;
        end else begin
          state_nxt = RESP;
        end
      end
      FILL: begin
        touch_en  = 1'b1;
        touch_way = victim;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Valid bits, request latch, response register and sticky multi-hit flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      lat_tag    <= '0;
      lat_alloc  <= 1'b0;
      resp_hit_q <= 1'b0;
      resp_way_q <= '0;
      multi_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            valid <= '0;
          end else if (bus.req_valid) begin
            lat_tag   <= bus.req_tag;
            lat_alloc <= bus.req_alloc;
          end
        end
        COMPARE: begin
          if (hit_any) begin
            resp_hit_q <= 1'b1;
            resp_way_q <= hit_way;
            if (hit_multi) multi_q <= 1'b1;
          end else if (!lat_alloc) begin
            resp_hit_q <= 1'b0;
            resp_way_q <= '0;
          end
        end
        FILL: begin
          valid[victim] <= 1'b1;
          resp_hit_q    <= 1'b0;
          resp_way_q    <= victim;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) && !bus.flush && !reset;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.tag_we     = (state == FILL && !reset) ? ({{(WAYS-1){1'b0}}, 1'b1} << victim) : '0;
  assign bus.tag_wdata  = (state == FILL && !reset) ? lat_tag : '0;
  assign bus.multi_hit  = multi_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: directed scenarios plus random lookups against a
// behavioural cache model (tag/valid arrays and a heap-indexed PLRU tree).
module tb_tag_lookup_ctrl;
  import tag_lookup_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;

  tag_lookup_ctrl_if bus();

  tag_lookup_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Tag array model: captures writes on the falling edge.
  logic [TAG_W-1:0] arr [WAYS];
  always_comb begin
    for (int w = 0; w < WAYS; w++) bus.tag_rd[w*TAG_W +: TAG_W] = arr[w];
  end

  // Behavioural model state.
  logic [WAYS-1:0]  m_valid;
  logic [TAG_W-1:0] m_tag [WAYS];
  logic [6:0]       m_plru;
  logic             m_multi;

  logic [WAY_W:0]          exp_q[$];
  logic [WAYS+TAG_W-1:0]   fill_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic m_touch(input int w);
    int node;
    node = 0;
    for (int l = 0; l < 3; l++) begin
      int dir;
      dir = (w >> (2 - l)) & 1;
      m_plru[node] = (dir == 0);
      node = 2 * node + 1 + dir;
    end
  endtask

  function automatic int m_victim();
    int node;
    node = 0;
    for (int l = 0; l < 3; l++) node = 2 * node + 1 + int'(m_plru[node]);
    return node - 7;
  endfunction

  task automatic model_access(input logic [TAG_W-1:0] tag, input logic alloc,
                              output logic hit, output logic [WAY_W-1:0] way, output int lat);
    int cnt, first, v;
    logic [WAYS-1:0] oh;
    cnt = 0; first = -1; v = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[w] && m_tag[w] == tag) begin
        cnt++;
        if (first < 0) first = w;
      end
    end
    if (cnt > 0) begin
      hit = 1'b1; way = WAY_W'(first); lat = 2;
      if (cnt > 1) m_multi = 1'b1;
      m_touch(first);
    end else if (!alloc) begin
      hit = 1'b0; way = '0; lat = 2;
    end else begin
      for (int w = 0; w < WAYS; w++) if (!m_valid[w] && v < 0) v = w;
      if (v < 0) v = m_victim();
      m_valid[v] = 1'b1;
      m_tag[v]   = tag;
      m_touch(v);
      oh = '0; oh[v] = 1'b1;
      fill_q.push_back({oh, tag});
      hit = 1'b0; way = WAY_W'(v); lat = 3;
    end
  endtask

  // Compare process: responses, fill writes and the sticky error flag.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
        end else begin
          check("resp_hit_way", 64'({bus.resp_hit, bus.resp_way}), 64'(exp_q[0]));
          check("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
          check("multi_hit", 64'(bus.multi_hit), 64'(m_multi));
          if (bus.resp_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.tag_we != '0) begin
        if (fill_q.size() == 0) begin
          check("tag_we_unexpected", 64'(bus.tag_we), 64'd0);
        end else begin
          check("fill_we_wdata", 64'({bus.tag_we, bus.tag_wdata}), 64'(fill_q.pop_front()));
        end
        for (int w = 0; w < WAYS; w++) if (bus.tag_we[w]) arr[w] = bus.tag_wdata;
      end
    end
  end

  // Driver tasks.
  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.resp_ready = 1'b0;
    m_valid = '0; m_plru = '0; m_multi = 1'b0;
    exp_q.delete(); fill_q.delete();
    repeat (cycles) begin
      @(negedge clk);
      check("req_ready_in_reset", 64'(bus.req_ready), 64'd0);
      check("tag_we_in_reset", 64'(bus.tag_we), 64'd0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
    check("rst_resp_way", 64'(bus.resp_way), 64'd0);
    check("rst_tag_we", 64'(bus.tag_we), 64'd0);
    check("rst_tag_wdata", 64'(bus.tag_wdata), 64'd0);
    check("rst_multi_hit", 64'(bus.multi_hit), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic lookup(input logic [TAG_W-1:0] tag, input logic alloc, input int hold,
                        output logic got_hit, output logic [WAY_W-1:0] got_way);
    logic eh;
    logic [WAY_W-1:0] ew;
    int el, lat, n;
    got_hit = 1'b0; got_way = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_tag = tag; bus.req_alloc = alloc;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
    if (!bus.req_ready) begin
      check("req_ready_wait", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_access(tag, alloc, eh, ew, el);
    exp_q.push_back({eh, ew});
    #1 bus.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'(el));
    if (!bus.resp_valid) return;
    got_hit = bus.resp_hit; got_way = bus.resp_way;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after_resp", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic flush_op(input logic with_req, input logic [TAG_W-1:0] tag);
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.req_valid = with_req; bus.req_tag = tag; bus.req_alloc = 1'b1;
    @(negedge clk);
    check("req_ready_during_flush", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    m_valid = '0; m_plru = '0;
    #1 bus.flush = 1'b0; bus.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_after_flush", 64'(state_dbg), 64'(IDLE));
    end
  endtask

  logic [TAG_W-1:0] tags [12];
  logic             gh;
  logic [WAY_W-1:0] gw;

  initial begin
    for (int w = 0; w < WAYS; w++) begin arr[w] = '0; m_tag[w] = '0; end
    bus.req_tag = '0; bus.req_alloc = 1'b0;
    for (int i = 0; i < 12; i++) tags[i] = TAG_W'(32'h100000 + i * 32'h010203 + $urandom_range(0, 255) * 32'h10000);
    apply_reset(3);

    // Plain miss on an empty store.
    lookup(24'h000000, 1'b0, 0, gh, gw);
    check("t1_hit", 64'(gh), 64'd0);
    check("t1_way", 64'(gw), 64'd0);

    // Allocate-miss then hit on the same tag.
    lookup(24'hABC123, 1'b1, 0, gh, gw);
    check("t2_alloc_way", 64'(gw), 64'd0);
    check("t2_store", 64'(arr[0]), 64'h0ABC123);
    lookup(24'hABC123, 1'b0, 0, gh, gw);
    check("t2_hit", 64'(gh), 64'd1);
    check("t2_hit_way", 64'(gw), 64'd0);

    // Fill all eight ways, touch 0,4,2, next victim must be way 6.
    flush_op(1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      lookup(tags[i], 1'b1, 0, gh, gw);
      check("t3_fill_way", 64'(gw), 64'(i));
    end
    lookup(tags[0], 1'b0, 0, gh, gw); check("t3_hit0", 64'({gh, gw}), 64'h8);
    lookup(tags[4], 1'b0, 0, gh, gw); check("t3_hit4", 64'({gh, gw}), 64'hC);
    lookup(tags[2], 1'b0, 0, gh, gw); check("t3_hit2", 64'({gh, gw}), 64'hA);
    check("t3_model_victim", 64'(m_victim()), 64'd6);
    lookup(tags[8], 1'b1, 0, gh, gw);
    check("t3_victim6", 64'({gh, gw}), 64'h6);

    // Backpressure: hold the response for five cycles.
    lookup(tags[8], 1'b0, 5, gh, gw);
    check("t4_held_way", 64'({gh, gw}), 64'hE);

    // Flush beats a simultaneous request; stored tags are gone.
    flush_op(1'b1, tags[1]);
    lookup(tags[1], 1'b0, 0, gh, gw);
    check("t5_miss", 64'({gh, gw}), 64'h0);
    lookup(tags[1], 1'b1, 0, gh, gw);
    check("t5_alloc_way0", 64'({gh, gw}), 64'h0);

    // Random traffic against the model.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) flush_op(1'($urandom_range(0, 1)), tags[$urandom_range(0, 11)]);
      else lookup(tags[$urandom_range(0, 11)], 1'($urandom_range(0, 1)), $urandom_range(0, 3), gh, gw);
    end

    // Reset while in FILL: no write, no response, valid cleared.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_tag = 24'h5A5A5A; bus.req_alloc = 1'b1;
    @(negedge clk);
    check("t6_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_in_fill", 64'(state_dbg), 64'(FILL));
    apply_reset(1);
    check("t6_no_write", 64'(arr[0] == 24'h5A5A5A), 64'd0);
    lookup(tags[1], 1'b0, 0, gh, gw);
    check("t6_valid_cleared", 64'({gh, gw}), 64'h0);

    // Duplicate tag in two ways: lower way wins, multi_hit sticks.
    lookup(tags[9], 1'b1, 0, gh, gw);
    lookup(tags[10], 1'b1, 0, gh, gw);
    check("t6_second_way", 64'(gw), 64'd1);
    arr[1] = tags[9]; m_tag[1] = tags[9];
    lookup(tags[9], 1'b0, 0, gh, gw);
    check("t6_multi_way", 64'({gh, gw}), 64'h8);
    check("t6_multi_flag", 64'(bus.multi_hit), 64'd1);
    lookup(tags[10], 1'b0, 0, gh, gw);
    check("t6_multi_sticky", 64'(bus.multi_hit), 64'd1);

    repeat (4) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("fill_q_drained", 64'(fill_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a wait escapes its bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
